// File: rtl/binary_search_ctrl.sv
// ---------------------------------------------------------------------------
// binary_search_ctrl
//
// Finds an unknown WIDTH-bit value by binary search against an external
// magnitude comparator. The controller presents a trial value on `guess`
// (wired to comparator A) and consumes the AltB/AeqB/AgtB flags. The hidden
// operand sits on comparator B outside this block.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request a new search (ignored while busy)
//   guess             trial value presented to the comparator
//   guess_valid       guess is presented and a comparator answer is awaited
//   cmp_valid         comparator flags are valid this cycle
//   AltB/AeqB/AgtB    comparator flags (guess <, ==, > target)
//   busy              search in progress
//   done              search succeeded, found is valid (held until start)
//   error             inconsistent comparator answers (held until start)
//   found             result of the last successful search
//   steps             probes issued in the current or last search
// ---------------------------------------------------------------------------
module binary_search_ctrl #(
    parameter int WIDTH  = 6,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [WIDTH-1:0]  guess,
    output logic              guess_valid,
    input  logic              cmp_valid,
    input  logic              AltB,
    input  logic              AeqB,
    input  logic              AgtB,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WIDTH-1:0]  found,
    output logic [STEP_W-1:0] steps
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PROBE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAIL  = 2'd3;

    localparam logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  ZERO_VAL = '0;
    localparam logic [WIDTH-1:0]  ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};
    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_reg, state_next;
    logic [WIDTH-1:0]  lo_reg, lo_next;
    logic [WIDTH-1:0]  hi_reg, hi_next;
    logic [WIDTH-1:0]  guess_reg, guess_next;
    logic [WIDTH-1:0]  found_reg, found_next;
    logic [STEP_W-1:0] steps_reg, steps_next;

    logic              one_hot;
    logic [WIDTH-1:0]  new_lo, new_hi;

    // Midpoint with a WIDTH+1-bit sum so lo+hi never wraps.
    function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH:1];
    endfunction

    // Exactly one flag set: odd parity excludes 0 and 2 set, AND excludes 3.
    assign one_hot = (AltB ^ AeqB ^ AgtB) & ~(AltB & AeqB & AgtB);
    assign new_lo  = guess_reg + ONE_VAL;
    assign new_hi  = guess_reg - ONE_VAL;

    always_comb begin
        state_next = state_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        guess_next = guess_reg;
        found_next = found_reg;
        steps_next = steps_reg;

        case (state_reg)
            S_PROBE: begin
                if (cmp_valid) begin
                    if (steps_reg != STEP_MAX) begin
                        steps_next = steps_reg + STEP_ONE;
                    end
                    if (!one_hot) begin
                        state_next = S_FAIL;
                    end else if (AeqB) begin
                        found_next = guess_reg;
                        state_next = S_DONE;
                    end else if (AltB) begin
                        if (guess_reg == MAX_VAL || new_lo > hi_reg) begin
                            state_next = S_FAIL;
                        end else begin
                            lo_next    = new_lo;
                            guess_next = mid_of(new_lo, hi_reg);
                        end
                    end else begin
                        // AgtB: guess==0 would underflow the upper bound.
                        if (guess_reg == ZERO_VAL || new_hi < lo_reg) begin
                            state_next = S_FAIL;
                        end else begin
                            hi_next    = new_hi;
                            guess_next = mid_of(lo_reg, new_hi);
                        end
                    end
                end
            end
            default: begin
                // IDLE, DONE and FAIL all accept a (re)start.
                if (start) begin
                    lo_next    = ZERO_VAL;
                    hi_next    = MAX_VAL;
                    steps_next = '0;
                    guess_next = mid_of(ZERO_VAL, MAX_VAL);
                    state_next = S_PROBE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            lo_reg    <= ZERO_VAL;
            hi_reg    <= MAX_VAL;
            guess_reg <= ZERO_VAL;
            found_reg <= ZERO_VAL;
            steps_reg <= '0;
        end else begin
            state_reg <= state_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            guess_reg <= guess_next;
            found_reg <= found_next;
            steps_reg <= steps_next;
        end
    end

    // Status outputs decode straight from the state register, so done/error
    // persist until the next start moves the FSM back into PROBE.
    assign guess       = guess_reg;
    assign guess_valid = (state_reg == S_PROBE);
    assign busy        = (state_reg == S_PROBE);
    assign done        = (state_reg == S_DONE);
    assign error       = (state_reg == S_FAIL);
    assign found       = found_reg;
    assign steps       = steps_reg;

endmodule

// File: tb/tb_binary_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_binary_search_ctrl
//
// Drives binary_search_ctrl against a behavioural comparator (with optional
// faulty answers) and checks results against a reference search model.
// ---------------------------------------------------------------------------
module tb_binary_search_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] guess;
    logic       guess_valid;
    logic       cmp_valid;
    logic       AltB, AeqB, AgtB;
    logic       busy, done, error;
    logic [5:0] found;
    logic [2:0] steps;

    logic [5:0] target;
    int         fault;      // 0: honest, 1: AltB+AgtB both high, 2: always AgtB

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] got_q[$];
    logic [5:0] exp_q[$];
    int         stable_bad;
    int         timed_out;

    always #5 clk = ~clk;

    binary_search_ctrl #(.WIDTH(6), .STEP_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .guess       (guess),
        .guess_valid (guess_valid),
        .cmp_valid   (cmp_valid),
        .AltB        (AltB),
        .AeqB        (AeqB),
        .AgtB        (AgtB),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .found       (found),
        .steps       (steps)
    );

    // Behavioural comparator standing in for the external stage.
    always_comb begin
        AltB = (guess < target);
        AeqB = (guess == target);
        AgtB = (guess > target);
        if (fault == 1) begin
            AltB = 1'b1; AeqB = 1'b0; AgtB = 1'b1;
        end else if (fault == 2) begin
            AltB = 1'b0; AeqB = 1'b0; AgtB = 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: textbook interval halving on integers.
    function automatic void build_ref(input int tgt);
        int lo, hi, g;
        exp_q.delete();
        lo = 0;
        hi = 63;
        for (int i = 0; i < 8; i++) begin
            g = (lo + hi) / 2;
            exp_q.push_back(6'(g));
            if (g == tgt) break;
            if (g < tgt) lo = g + 1;
            else         hi = g - 1;
        end
    endfunction

    function automatic int seq_match();
        if (got_q.size() != exp_q.size()) return 0;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i] != exp_q[i]) return 0;
        return 1;
    endfunction

    // period 0 = random cmp_valid; otherwise a pulse every `period` cycles.
    task automatic run_search(input logic [5:0] tgt, input int period,
                              input int fmode, input bit rand_start);
        bit         cv, prev_gv, prev_cv;
        logic [5:0] prev_g;
        target     = tgt;
        fault      = fmode;
        got_q.delete();
        stable_bad = 0;
        prev_gv    = 1'b0;
        prev_cv    = 1'b0;
        prev_g     = '0;
        @(negedge clk);
        start     = 1'b1;
        cmp_valid = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        timed_out = 1;
        for (int c = 0; c < 400; c++) begin
            if (!busy) begin
                timed_out = 0;
                break;
            end
            if (prev_gv && guess_valid && !prev_cv && guess != prev_g)
                stable_bad++;
            if (period == 0) cv = ($urandom_range(0, 1) == 1);
            else             cv = ((c % period) == period - 1);
            if (guess_valid && cv) got_q.push_back(guess);
            prev_gv   = guess_valid;
            prev_cv   = cv;
            prev_g    = guess;
            cmp_valid = cv;
            start     = rand_start ? ($urandom_range(0, 1) == 1) : 1'b0;
            @(negedge clk);
        end
        cmp_valid = 1'b0;
        start     = 1'b0;
        chk("timeout", timed_out, 0);
        chk("guess_stable", stable_bad, 0);
        chk("idle_guess_valid", int'(guess_valid), 0);
    endtask

    typedef struct {
        logic [5:0] tgt;
        int         period;
        int         fault;
        logic       exp_done;
        logic       exp_err;
        logic [5:0] exp_found;
        int         exp_steps;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{6'd42, 1, 0, 1'b1, 1'b0, 6'd42, 6};
        vecs[1] = '{6'd63, 1, 0, 1'b1, 1'b0, 6'd63, 7};
        vecs[2] = '{6'd0,  1, 0, 1'b1, 1'b0, 6'd0,  6};
        vecs[3] = '{6'd17, 1, 1, 1'b0, 1'b1, 6'd0,  1};  // found stays from prior
        vecs[4] = '{6'd42, 3, 0, 1'b1, 1'b0, 6'd42, 6};
        vecs[5] = '{6'd5,  1, 2, 1'b0, 1'b1, 6'd42, 6};  // fails after guess 0

        rst_n     = 1'b0;
        start     = 1'b0;
        cmp_valid = 1'b0;
        target    = '0;
        fault     = 0;

        #1;
        chk("rst_guess", int'(guess), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_steps", int'(steps), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_search(vecs[v].tgt, vecs[v].period, vecs[v].fault, 1'b0);
            chk($sformatf("v%0d_done", v),  int'(done),  int'(vecs[v].exp_done));
            chk($sformatf("v%0d_error", v), int'(error), int'(vecs[v].exp_err));
            chk($sformatf("v%0d_found", v), int'(found), int'(vecs[v].exp_found));
            chk($sformatf("v%0d_steps", v), int'(steps), vecs[v].exp_steps);
            if (vecs[v].fault == 0) begin
                build_ref(int'(vecs[v].tgt));
                chk($sformatf("v%0d_seq", v), seq_match(), 1);
            end
            $display("vec %0d target=%0d period=%0d fault=%0d done=%0d error=%0d found=%0d steps=%0d",
                     v, vecs[v].tgt, vecs[v].period, vecs[v].fault, done, error, found, steps);
        end

        // Reset asserted while the third guess is on the bus.
        target    = 6'd42;
        fault     = 0;
        @(negedge clk);
        start     = 1'b1;
        cmp_valid = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_third_guess", int'(guess), 39);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_guess", int'(guess), 0);
        chk("mid_rst_gvalid", int'(guess_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_error", int'(error), 0);
        chk("mid_rst_found", int'(found), 0);
        chk("mid_rst_steps", int'(steps), 0);
        @(negedge clk);
        cmp_valid = 1'b0;
        rst_n     = 1'b1;
        run_search(6'd42, 1, 0, 1'b0);
        chk("post_rst_done", int'(done), 1);
        chk("post_rst_found", int'(found), 42);
        chk("post_rst_steps", int'(steps), 6);
        $display("reset-abort then search target=42 done=%0d found=%0d steps=%0d", done, found, steps);

        // Random targets, random cmp_valid pacing, stray start pulses while busy.
        for (int r = 0; r < 20; r++) begin
            logic [5:0] t;
            t = 6'($urandom_range(0, 63));
            run_search(t, 0, 0, 1'b1);
            build_ref(int'(t));
            chk($sformatf("r%0d_done", r),  int'(done), 1);
            chk($sformatf("r%0d_error", r), int'(error), 0);
            chk($sformatf("r%0d_found", r), int'(found), int'(t));
            chk($sformatf("r%0d_steps", r), int'(steps), exp_q.size());
            chk($sformatf("r%0d_seq", r),   seq_match(), 1);
            $display("rand %0d target=%0d found=%0d steps=%0d probes_seen=%0d",
                     r, t, found, steps, got_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
